// File: rtl/ob_match_if.sv
// Shared order-book record types and the matcher's table/trade port bundle.
// master: matcher side (consumes table heads, drives pop/upt pulses and trade record).
// slave: environment side (ob_table heads, trade consumer).

package ob_match_pkg;

    // One resting order as presented by an ob_table head.
    // price is BCD-encoded; an unsigned compare on the raw bits orders it correctly.
    typedef struct packed {
        logic [15:0] uid;
        logic [15:0] quantity;
        logic [31:0] price;
    } table_t;

    // One executed trade.
    typedef struct packed {
        logic [15:0] bid_uid;
        logic [15:0] ask_uid;
        logic [31:0] price;
        logic [15:0] quantity;
    } trade_t;

endpackage

interface ob_match_if;
    import ob_match_pkg::*;

    // table heads
    logic   bid_head_vld;
    table_t bid_head;
    logic   ask_head_vld;
    table_t ask_head;

    // head maintenance pulses back to the tables
    logic   bid_pop;
    logic   bid_upt;
    table_t bid_upt_tbl;
    logic   ask_pop;
    logic   ask_upt;
    table_t ask_upt_tbl;

    // trade record valid/ready port
    logic   trade_vld_r;
    logic   trade_rdy;
    trade_t trade_r;

    modport master (
        input  bid_head_vld, bid_head, ask_head_vld, ask_head, trade_rdy,
        output bid_pop, bid_upt, bid_upt_tbl, ask_pop, ask_upt, ask_upt_tbl,
        output trade_vld_r, trade_r
    );

    modport slave (
        output bid_head_vld, bid_head, ask_head_vld, ask_head, trade_rdy,
        input  bid_pop, bid_upt, bid_upt_tbl, ask_pop, ask_upt, ask_upt_tbl,
        input  trade_vld_r, trade_r
    );

endinterface

// File: rtl/ob_match.sv
// Order-book matching controller: crosses bid/ask table heads into trade records.
// Latency: trade_r registered 1 cycle after heads cross; pop/upt pulses in the handshake cycle.
// Backpressure: trade record held stable until trade_rdy; busy_r stalls table inserts/cancels.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en           matching enable (only gates starting a new match)
//   mif          ob_match_if.master: table heads, pop/upt pulses, trade valid/ready
//   busy_r       registered, high whenever the matcher is not idle next cycle
//   trade_cnt_r  wrapping count of accepted trades

module ob_match
    import ob_match_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    ob_match_if.master       mif,
    output logic             busy_r,
    output logic [CNT_W-1:0] trade_cnt_r
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt;

    // Heads as they were when the match started; pulses are derived from these
    // so later head activity cannot corrupt the rewrite.
    table_t bid_snap_r;
    table_t ask_snap_r;

    logic        crossed;
    logic        bid_zero;
    logic        ask_zero;
    logic        handshake;
    logic        start_trade;
    logic        zero_pop;
    logic [15:0] min_qty;
    trade_t      trade_nxt;

    // ------------------------------------------------------------------
    // Head qualification
    // ------------------------------------------------------------------
    assign crossed  = mif.bid_head_vld & mif.ask_head_vld &
                      (mif.bid_head.price >= mif.ask_head.price);

    // Zero-quantity heads should never reach us; they are flushed rather than traded.
    assign bid_zero = mif.bid_head_vld & (mif.bid_head.quantity == 16'd0);
    assign ask_zero = mif.ask_head_vld & (mif.ask_head.quantity == 16'd0);

    assign min_qty  = (mif.bid_head.quantity < mif.ask_head.quantity) ?
                      mif.bid_head.quantity : mif.ask_head.quantity;

    always_comb begin
        trade_nxt          = '0;
        trade_nxt.bid_uid  = mif.bid_head.uid;
        trade_nxt.ask_uid  = mif.ask_head.uid;
        trade_nxt.price    = mif.ask_head.price;   // resting ask sets the price
        trade_nxt.quantity = min_qty;
    end

    // A reset cycle must never let a handshake through: the record is dropped.
    assign handshake = (state_r == EMIT) & mif.trade_vld_r & mif.trade_rdy & ~rst;

    // ------------------------------------------------------------------
    // Next state and head-maintenance pulses
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state_r;
        start_trade     = 1'b0;
        zero_pop        = 1'b0;
        mif.bid_pop     = 1'b0;
        mif.bid_upt     = 1'b0;
        mif.bid_upt_tbl = '0;
        mif.ask_pop     = 1'b0;
        mif.ask_upt     = 1'b0;
        mif.ask_upt_tbl = '0;

        unique case (state_r)
            IDLE: begin
                if (en & ~rst) begin
                    if (bid_zero | ask_zero) begin
                        zero_pop  = 1'b1;
                        state_nxt = SETTLE;
                    end else if (crossed) begin
                        start_trade = 1'b1;
                        state_nxt   = EMIT;
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // Gives the table head registers a cycle to reflect the pop/upt.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (zero_pop) begin
            mif.bid_pop = bid_zero;
            mif.ask_pop = ask_zero;
        end

        if (handshake) begin
            if (bid_snap_r.quantity == ask_snap_r.quantity) begin
                mif.bid_pop = 1'b1;
                mif.ask_pop = 1'b1;
            end else if (bid_snap_r.quantity > ask_snap_r.quantity) begin
                mif.ask_pop              = 1'b1;
                mif.bid_upt              = 1'b1;
                mif.bid_upt_tbl          = bid_snap_r;
                mif.bid_upt_tbl.quantity = bid_snap_r.quantity - ask_snap_r.quantity;
            end else begin
                mif.bid_pop              = 1'b1;
                mif.ask_upt              = 1'b1;
                mif.ask_upt_tbl          = ask_snap_r;
                mif.ask_upt_tbl.quantity = ask_snap_r.quantity - bid_snap_r.quantity;
            end
        end

        if (rst) begin
            state_nxt = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State, trade record, snapshots, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            busy_r          <= 1'b0;
            mif.trade_vld_r <= 1'b0;
            mif.trade_r     <= '0;
            bid_snap_r      <= '0;
            ask_snap_r      <= '0;
            trade_cnt_r     <= '0;
        end else begin
            state_r <= state_nxt;
            busy_r  <= (state_nxt != IDLE);

            if (start_trade) begin
                mif.trade_vld_r <= 1'b1;
                mif.trade_r     <= trade_nxt;
                bid_snap_r      <= mif.bid_head;
                ask_snap_r      <= mif.ask_head;
            end else if (handshake) begin
                mif.trade_vld_r <= 1'b0;
                trade_cnt_r     <= trade_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ob_match.sv
// Bench for ob_match: two order queues stand in for the bid/ask tables; a
// transaction-level model decides what each cycle must show and every cycle is checked.
module tb_ob_match;
    import ob_match_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        busy_r;
    logic [31:0] trade_cnt_r;

    ob_match_if bus();

    ob_match #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mif         (bus),
        .busy_r      (busy_r),
        .trade_cnt_r (trade_cnt_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // table contents, head at index 0
    table_t bq[$];
    table_t aq[$];

    // model state
    logic        m_vld    = 1'b0;
    logic        m_settle = 1'b0;
    logic        m_busy   = 1'b0;
    logic [31:0] m_cnt    = '0;
    trade_t      m_trade  = '0;
    table_t      m_sb     = '0;
    table_t      m_sa     = '0;

    // captures for directed expectations
    trade_t      hs_trade[$];
    logic [3:0]  hs_pulse[$];
    table_t      hs_bupt[$];
    int          hs_cyc[$];
    int          dut_pulses = 0;
    logic        busy_seen  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_caps();
        hs_trade.delete();
        hs_pulse.delete();
        hs_bupt.delete();
        hs_cyc.delete();
        dut_pulses = 0;
        busy_seen  = 1'b0;
    endtask

    // One clock: drive inputs, check the DUT against the model, advance the model.
    task automatic step(input logic en_i, input logic rdy_i, input logic rst_i);
        logic   bvld, avld, e_bp, e_bu, e_ap, e_au, nxt_vld, nxt_settle;
        table_t bh, ah, e_bt, e_at, t;
        @(negedge clk);
        rst = rst_i;
        en  = en_i;
        bus.trade_rdy    = rdy_i;
        bvld             = (bq.size() > 0);
        avld             = (aq.size() > 0);
        bh               = bvld ? bq[0] : '0;
        ah               = avld ? aq[0] : '0;
        bus.bid_head_vld = bvld;
        bus.bid_head     = bh;
        bus.ask_head_vld = avld;
        bus.ask_head     = ah;
        #1;
        cyc++;

        e_bp = 0; e_bu = 0; e_ap = 0; e_au = 0; e_bt = '0; e_at = '0;
        nxt_vld = m_vld; nxt_settle = 1'b0;

        // registered outputs reflect the previous edge
        chk("trade_vld_r", bus.trade_vld_r, m_vld);
        if (m_vld) chk("trade_r", bus.trade_r, m_trade);
        chk("busy_r", busy_r, m_busy);
        chk("trade_cnt_r", trade_cnt_r, m_cnt);

        if (!rst_i) begin
            if (m_vld && rdy_i) begin
                // accepted: settle the quantities of the two matched orders
                if (m_sb.quantity == m_sa.quantity) begin
                    e_bp = 1; e_ap = 1;
                end else if (m_sb.quantity > m_sa.quantity) begin
                    e_ap = 1; e_bu = 1; e_bt = m_sb;
                    e_bt.quantity = m_sb.quantity - m_sa.quantity;
                end else begin
                    e_bp = 1; e_au = 1; e_at = m_sa;
                    e_at.quantity = m_sa.quantity - m_sb.quantity;
                end
                nxt_vld = 1'b0; nxt_settle = 1'b1;
                hs_trade.push_back(bus.trade_r);
                hs_pulse.push_back({bus.bid_pop, bus.bid_upt, bus.ask_pop, bus.ask_upt});
                hs_bupt.push_back(bus.bid_upt_tbl);
                hs_cyc.push_back(cyc);
            end else if (!m_vld && !m_settle && en_i) begin
                if ((bvld && bh.quantity == 0) || (avld && ah.quantity == 0)) begin
                    e_bp = bvld && bh.quantity == 0;
                    e_ap = avld && ah.quantity == 0;
                    nxt_settle = 1'b1;
                end else if (bvld && avld && bh.price >= ah.price) begin
                    nxt_vld = 1'b1;
                    m_trade = {bh.uid, ah.uid, ah.price,
                               (bh.quantity < ah.quantity) ? bh.quantity : ah.quantity};
                    m_sb = bh;
                    m_sa = ah;
                end
            end
        end

        chk("pulses", {bus.bid_pop, bus.bid_upt, bus.ask_pop, bus.ask_upt}, {e_bp, e_bu, e_ap, e_au});
        if (e_bu) chk("bid_upt_tbl", bus.bid_upt_tbl, e_bt);
        if (e_au) chk("ask_upt_tbl", bus.ask_upt_tbl, e_at);
        if (bus.bid_pop | bus.bid_upt | bus.ask_pop | bus.ask_upt) dut_pulses++;
        if (busy_r) busy_seen = 1'b1;

        if (rst_i) begin
            m_vld = 0; m_settle = 0; m_busy = 0; m_cnt = '0;
        end else begin
            if (e_bp) void'(bq.pop_front());
            if (e_ap) void'(aq.pop_front());
            if (e_bu) begin t = bq[0]; t.quantity = e_bt.quantity; bq[0] = t; end
            if (e_au) begin t = aq[0]; t.quantity = e_at.quantity; aq[0] = t; end
            if (m_vld && rdy_i) m_cnt = m_cnt + 1;
            m_vld    = nxt_vld;
            m_settle = nxt_settle;
            m_busy   = nxt_vld | nxt_settle;
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    function automatic table_t mk(input int uid, input int q, input logic [31:0] p);
        table_t t;
        t.uid = 16'(uid);
        t.quantity = 16'(q);
        t.price = p;
        return t;
    endfunction

    function automatic table_t rnd_order();
        table_t t;
        t.uid      = 16'($urandom);
        t.quantity = ($urandom_range(0, 19) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
        t.price    = 32'h90 + 32'($urandom_range(0, 9));
        return t;
    endfunction

    initial begin
        bus.trade_rdy    = 1'b0;
        bus.bid_head_vld = 1'b0;
        bus.bid_head     = '0;
        bus.ask_head_vld = 1'b0;
        bus.ask_head     = '0;

        // reset values
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        chk("rst trade_vld_r", bus.trade_vld_r, 1'b0);
        chk("rst trade_r", bus.trade_r, 80'd0);
        chk("rst busy_r", busy_r, 1'b0);
        chk("rst trade_cnt_r", trade_cnt_r, 32'd0);

        // equal quantities cross: both heads popped
        do_reset(); clear_caps();
        bq = '{mk(1, 10, 32'h100)}; aq = '{mk(2, 10, 32'h99)};
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("t1 trades", hs_trade.size(), 1);
        if (hs_trade.size() == 1) begin
            chk("t1 trade", hs_trade[0], {16'd1, 16'd2, 32'h99, 16'd10});
            chk("t1 pulses", hs_pulse[0], 4'b1010);
        end
        chk("t1 cnt", trade_cnt_r, 32'd1);

        // larger bid is rewritten, ask popped
        do_reset(); clear_caps();
        bq = '{mk(3, 15, 32'h100)}; aq = '{mk(4, 5, 32'h100)};
        repeat (3) step(1'b1, 1'b1, 1'b0);
        chk("t2 trades", hs_trade.size(), 1);
        if (hs_trade.size() == 1) begin
            chk("t2 trade", hs_trade[0], {16'd3, 16'd4, 32'h100, 16'd5});
            chk("t2 pulses", hs_pulse[0], 4'b0110);
            chk("t2 bid_upt_tbl", hs_bupt[0], {16'd3, 16'd10, 32'h100});
        end

        // uncrossed book: nothing happens
        do_reset();
        bq = '{mk(5, 3, 32'h98)}; aq = '{mk(6, 3, 32'h99)};
        clear_caps();
        repeat (6) step(1'b1, 1'b1, 1'b0);
        chk("t3 trades", hs_trade.size(), 0);
        chk("t3 pulses", dut_pulses, 0);
        chk("t3 busy", busy_seen, 1'b0);

        // consumer stalls for 4 cycles
        do_reset(); clear_caps();
        bq = '{mk(7, 4, 32'h99)}; aq = '{mk(8, 4, 32'h99)};
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("t4 held vld", bus.trade_vld_r, 1'b1);
            chk("t4 held trade", bus.trade_r, {16'd7, 16'd8, 32'h99, 16'd4});
        end
        chk("t4 no early pulses", dut_pulses, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t4 cnt", trade_cnt_r, 32'd1);
        if (hs_pulse.size() == 1) chk("t4 pulses", hs_pulse[0], 4'b1010);
        else chk("t4 handshakes", hs_pulse.size(), 1);

        // reset while a trade is outstanding
        bq = '{mk(9, 2, 32'h95)}; aq = '{mk(10, 1, 32'h90)};
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t5 pre-rst cnt", trade_cnt_r, 32'd1);
        clear_caps();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t5 vld", bus.trade_vld_r, 1'b0);
        chk("t5 busy", busy_r, 1'b0);
        chk("t5 cnt", trade_cnt_r, 32'd0);
        chk("t5 pulses", dut_pulses, 0);
        chk("t5 book intact", bq.size() + aq.size(), 2);

        // one bid sweeps three resting asks
        do_reset(); clear_caps();
        aq = '{mk(11, 1, 32'h50), mk(12, 1, 32'h50), mk(13, 1, 32'h50)};
        bq = '{mk(20, 3, 32'h60)};
        repeat (14) step(1'b1, 1'b1, 1'b0);
        chk("t6 trades", hs_trade.size(), 3);
        if (hs_trade.size() == 3) begin
            chk("t6 upt1 q", hs_bupt[0].quantity, 16'd2);
            chk("t6 upt2 q", hs_bupt[1].quantity, 16'd1);
            chk("t6 last pulses", hs_pulse[2], 4'b1010);
            chk("t6 gap1", (hs_cyc[1] - hs_cyc[0]) >= 3, 1'b1);
            chk("t6 gap2", (hs_cyc[2] - hs_cyc[1]) >= 3, 1'b1);
        end
        chk("t6 cnt", trade_cnt_r, 32'd3);

        // randomized traffic
        do_reset();
        bq.delete(); aq.delete();
        for (int i = 0; i < 3000; i++) begin
            if (!m_busy && !m_vld) begin
                if (bq.size() < 6 && $urandom_range(0, 9) < 3) bq.push_back(rnd_order());
                if (aq.size() < 6 && $urandom_range(0, 9) < 3) aq.push_back(rnd_order());
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
